// File: rtl/enet_rx_frame_buf.sv
// Rx frame buffer: stores MAC Rx frames in RAM, commits on good CRC + address match, replays them with length.
// Latency: first output beat is valid 2 cycles after the committing (last) input beat.
// Backpressure: none on the Rx side (frames that do not fit are dropped); output holds while out_accept_i=0.
// Optional feature macro: ENET_RX_ADDR_FILTER_EN enables the destination-MAC filter.
module enet_rx_frame_buf #(
  parameter int ADDR_W     = 9,
  parameter int STS_ADDR_W = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_valid_i,
  input  logic [31:0] rx_data_i,
  input  logic [3:0]  rx_strb_i,
  input  logic        rx_last_i,
  input  logic        rx_crc_valid_i,
  input  logic [47:0] mac_addr_i,
  input  logic        promisc_i,
  output logic        out_valid_o,
  output logic [31:0] out_data_o,
  output logic [3:0]  out_strb_o,
  output logic        out_last_o,
  output logic [15:0] out_len_o,
  input  logic        out_accept_i,
  output logic [15:0] drop_count_o
);

  localparam int DEPTH     = 1 << ADDR_W;
  localparam int STS_DEPTH = 1 << STS_ADDR_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RECV = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  // Number of valid bytes in a contiguous-from-bit-0 strobe.
  function automatic logic [2:0] f_popcnt(input logic [3:0] s);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) n = n + {2'b00, s[i]};
    return n;
  endfunction

  // Byte enables of the final beat, from the low bits of the frame length.
  function automatic logic [3:0] f_last_strb(input logic [1:0] l);
    logic [3:0] s;
    case (l)
      2'd1:    s = 4'h1;
      2'd2:    s = 4'h3;
      2'd3:    s = 4'h7;
      default: s = 4'hF;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------- storage
  logic [31:0]       r_mem       [DEPTH];
  logic [15:0]       r_sts_len   [STS_DEPTH];
  logic [15:0]       r_sts_words [STS_DEPTH];

  // ---------------------------------------------------------------- write side state
  logic [1:0]        r_wr_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_commit_ptr;
  logic [ADDR_W-1:0] r_free_ptr;
  logic [15:0]       r_beat_cnt;
  logic [31:0]       r_dst_hi;
  logic [15:0]       r_drop_count;

  // ---------------------------------------------------------------- status FIFO pointers (extra wrap bit)
  logic [STS_ADDR_W:0] r_sts_wr;
  logic [STS_ADDR_W:0] r_sts_rd;
  logic [STS_ADDR_W:0] r_sts_fetch;

  // ---------------------------------------------------------------- read side state
  logic [ADDR_W-1:0] r_rd_base;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [15:0]       r_fetch_rem;
  logic [15:0]       r_fetch_len;
  logic              r_q_vld;
  logic [31:0]       r_q_dat;
  logic              r_q_last;
  logic [15:0]       r_q_len;
  logic              r_out_vld;
  logic [31:0]       r_out_dat;
  logic [3:0]        r_out_strb;
  logic              r_out_last;
  logic [15:0]       r_out_len;

  // ---------------------------------------------------------------- write side combinational
  logic [ADDR_W-1:0] w_wr_ptr_nxt;
  logic              w_ram_full;
  logic              w_sts_full;
  logic [47:0]       w_dst;
  logic              w_addr_ok;
  logic              w_match_now;
  logic [15:0]       w_len;
  logic [15:0]       w_words;
  logic [1:0]        w_nxt_state;
  logic              w_wr_en;
  logic              w_commit;
  logic              w_drop;

  assign w_wr_ptr_nxt = r_wr_ptr + ADDR_W'(1);
  // Free space is judged against the reader's pointer as seen one cycle late.
  assign w_ram_full   = (w_wr_ptr_nxt == r_free_ptr);
  assign w_sts_full   = (r_sts_wr[STS_ADDR_W] != r_sts_rd[STS_ADDR_W]) &&
                        (r_sts_wr[STS_ADDR_W-1:0] == r_sts_rd[STS_ADDR_W-1:0]);

  // Destination address: bytes 0-3 from the first beat, bytes 4-5 from the current (second) beat.
  assign w_dst = {r_dst_hi[7:0], r_dst_hi[15:8], r_dst_hi[23:16], r_dst_hi[31:24],
                  rx_data_i[7:0], rx_data_i[15:8]};

`ifdef ENET_RX_ADDR_FILTER_EN
  assign w_addr_ok = (w_dst == mac_addr_i) || (&w_dst) || promisc_i;
`else
  logic w_unused_filter;
  assign w_unused_filter = ^{w_dst, mac_addr_i, promisc_i};
  assign w_addr_ok       = 1'b1;
`endif

  // Only the second beat carries the decision; later beats are past the check.
  assign w_match_now = (r_beat_cnt == 16'd1) ? w_addr_ok : 1'b1;
  assign w_len       = {r_beat_cnt[13:0], 2'b00} + {13'd0, f_popcnt(rx_strb_i)};
  assign w_words     = r_beat_cnt + 16'd1;

  // Write FSM next state and per-beat events.
  always_comb begin
    w_nxt_state = r_wr_state;
    w_wr_en     = 1'b0;
    w_commit    = 1'b0;
    w_drop      = 1'b0;
    if (rx_valid_i) begin
      case (r_wr_state)
        S_IDLE: begin
          if (rx_last_i) begin
            w_drop = 1'b1;
          end else if (w_sts_full || w_ram_full) begin
            w_nxt_state = S_DROP;
          end else begin
            w_wr_en     = 1'b1;
            w_nxt_state = S_RECV;
          end
        end
        S_RECV: begin
          if (w_ram_full || !w_match_now) begin
            if (rx_last_i) begin
              w_drop      = 1'b1;
              w_nxt_state = S_IDLE;
            end else begin
              w_nxt_state = S_DROP;
            end
          end else begin
            w_wr_en = 1'b1;
            if (rx_last_i) begin
              w_nxt_state = S_IDLE;
              if (rx_crc_valid_i) w_commit = 1'b1;
              else                w_drop   = 1'b1;
            end
          end
        end
        S_DROP: begin
          if (rx_last_i) begin
            w_drop      = 1'b1;
            w_nxt_state = S_IDLE;
          end
        end
        default: w_nxt_state = S_IDLE;
      endcase
    end
  end

  // Write FSM state, pointers, commit/rollback and drop counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_state   <= S_IDLE;
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_beat_cnt   <= '0;
      r_dst_hi     <= '0;
      r_drop_count <= '0;
      r_sts_wr     <= '0;
    end else begin
      r_wr_state <= w_nxt_state;
      if (w_drop)       r_wr_ptr <= r_commit_ptr;
      else if (w_wr_en) r_wr_ptr <= w_wr_ptr_nxt;
      if (w_commit) begin
        r_commit_ptr <= w_wr_ptr_nxt;
        r_sts_wr     <= r_sts_wr + 1'b1;
      end
      if (w_wr_en) begin
        if (r_wr_state == S_IDLE) begin
          r_beat_cnt <= 16'd1;
          r_dst_hi   <= rx_data_i;
        end else begin
          r_beat_cnt <= r_beat_cnt + 16'd1;
        end
      end
      if (w_drop && (r_drop_count != 16'hFFFF)) r_drop_count <= r_drop_count + 16'd1;
    end
  end

  // Frame data RAM write port and status FIFO entry write (no reset needed on contents).
  always_ff @(posedge clk_i) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= rx_data_i;
    if (w_commit) begin
      r_sts_len[r_sts_wr[STS_ADDR_W-1:0]]   <= w_len;
      r_sts_words[r_sts_wr[STS_ADDR_W-1:0]] <= w_words;
    end
  end

  // ---------------------------------------------------------------- read side combinational
  logic        w_start;
  logic        w_out_load;
  logic        w_fetch;
  logic [15:0] w_rem_now;
  logic [15:0] w_len_now;
  logic        w_pop;

  // A new descriptor is taken when the current frame is fully fetched and another is committed.
  assign w_start    = (r_fetch_rem == 16'd0) && (r_sts_fetch != r_sts_wr);
  assign w_out_load = !r_out_vld || out_accept_i;
  assign w_fetch    = ((r_fetch_rem != 16'd0) || w_start) && (!r_q_vld || w_out_load);
  assign w_rem_now  = w_start ? r_sts_words[r_sts_fetch[STS_ADDR_W-1:0]] : r_fetch_rem;
  assign w_len_now  = w_start ? r_sts_len[r_sts_fetch[STS_ADDR_W-1:0]]   : r_fetch_len;
  assign w_pop      = r_out_vld && out_accept_i && r_out_last;

  // Fetch control, read pipeline stage, output skid register, status FIFO pop and space release.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sts_rd    <= '0;
      r_sts_fetch <= '0;
      r_rd_base   <= '0;
      r_rd_ptr    <= '0;
      r_free_ptr  <= '0;
      r_fetch_rem <= '0;
      r_fetch_len <= '0;
      r_q_vld     <= 1'b0;
      r_q_last    <= 1'b0;
      r_q_len     <= '0;
      r_out_vld   <= 1'b0;
      r_out_dat   <= '0;
      r_out_strb  <= '0;
      r_out_last  <= 1'b0;
      r_out_len   <= '0;
    end else begin
      if (w_fetch) begin
        r_q_vld     <= 1'b1;
        r_q_last    <= (w_rem_now == 16'd1);
        r_q_len     <= w_len_now;
        r_rd_ptr    <= r_rd_ptr + ADDR_W'(1);
        r_fetch_rem <= w_rem_now - 16'd1;
        r_fetch_len <= w_len_now;
        if (w_start) r_sts_fetch <= r_sts_fetch + 1'b1;
      end else if (w_out_load) begin
        r_q_vld <= 1'b0;
      end
      if (w_out_load) begin
        r_out_vld <= r_q_vld;
        if (r_q_vld) begin
          r_out_dat  <= r_q_dat;
          r_out_strb <= r_q_last ? f_last_strb(r_q_len[1:0]) : 4'hF;
          r_out_last <= r_q_last;
          r_out_len  <= r_q_len;
        end
      end
      if (w_pop) begin
        r_sts_rd  <= r_sts_rd + 1'b1;
        r_rd_base <= r_rd_base + r_sts_words[r_sts_rd[STS_ADDR_W-1:0]][ADDR_W-1:0];
      end
      r_free_ptr <= r_rd_base;
    end
  end

  // Registered RAM read port.
  always_ff @(posedge clk_i) begin
    if (w_fetch) r_q_dat <= r_mem[r_rd_ptr];
  end

  assign out_valid_o  = r_out_vld;
  assign out_data_o   = r_out_dat;
  assign out_strb_o   = r_out_strb;
  assign out_last_o   = r_out_last;
  assign out_len_o    = r_out_len;
  assign drop_count_o = r_drop_count;

endmodule
